// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative multiply/divide unit with a fixed-latency multiply and
//            a radix-2 restoring divider. result = {hi, lo}.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic [1:0]           op,
    input  logic                 start,
    input  logic                 flush,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int c_cw = $clog2(WIDTH + 1);
    localparam logic [c_cw-1:0] c_mul_cnt = c_cw'(MUL_LAT - 1);
    localparam logic [c_cw-1:0] c_div_cnt = c_cw'(WIDTH);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_div  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]          r_state;
    logic                r_busy;
    logic                r_valid;
    logic [2*WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic [c_cw-1:0]     r_cnt;
    logic                r_sgn;
    logic                r_zero;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_neg_a;
    logic                w_neg_b;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [2*WIDTH-1:0]  w_ea;
    logic [2*WIDTH-1:0]  w_eb;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_diff;

    // Signed ops are the ones with op[0] clear (MULT, DIV).
    assign w_neg_a = ~op[0] & src_a[WIDTH-1];
    assign w_neg_b = ~op[0] & src_b[WIDTH-1];
    assign w_abs_a = w_neg_a ? -src_a : src_a;
    assign w_abs_b = w_neg_b ? -src_b : src_b;

    assign w_ea   = {{WIDTH{r_sgn & r_a[WIDTH-1]}}, r_a};
    assign w_eb   = {{WIDTH{r_sgn & r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ea * w_eb;

    // Bit WIDTH of the difference is the borrow: set means "does not fit".
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign result = r_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_idle;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_sgn    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (flush) begin
            r_state <= c_idle;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_mul: begin
                    if (r_cnt == '0) begin
                        r_state  <= c_done;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= w_prod;
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                c_div: begin
                    if (r_zero) begin
                        r_state  <= c_done;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= {r_a, {WIDTH{1'b1}}};
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cw'(1);
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_state  <= c_done;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= {(r_neg_r ? -r_rem : r_rem),
                                     (r_neg_q ? -r_quo : r_quo)};
                    end
                end
                default: begin
                    // IDLE and DONE: both may accept a new operation.
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                    if (start) begin
                        r_busy <= 1'b1;
                        r_a    <= src_a;
                        r_sgn  <= ~op[0];
                        if (!op[1]) begin
                            r_state <= c_mul;
                            r_b     <= src_b;
                            r_cnt   <= c_mul_cnt;
                        end else begin
                            r_state <= c_div;
                            r_b     <= w_abs_b;
                            r_zero  <= (src_b == '0);
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            r_cnt   <= c_div_cnt;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed vector bench for mdu_iter (WIDTH=32, MUL_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [1:0]  op;
    logic        start;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[12];

    mdu_iter #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .src_a  (src_a),
        .src_b  (src_b),
        .op     (op),
        .start  (start),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Presents an operation for one edge, then scrambles the operand inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        op    = 2'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [63:0] prev;

        vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003,  2, 64'hFFFFFFFF_FFFFFFFA};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,  2, 64'hFFFFFFFE_00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 33, 64'hFFFFFFFF_FFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000};
        vecs[4]  = '{2'b11, 32'h00000064, 32'h00000000,  1, 64'h00000064_FFFFFFFF};
        vecs[5]  = '{2'b11, 32'h00000064, 32'h00000007, 33, 64'h00000002_0000000E};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD};
        vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000,  2, 64'h40000000_00000000};
        vecs[8]  = '{2'b01, 32'h00000003, 32'h00000005,  2, 64'h00000000_0000000F};
        vecs[9]  = '{2'b10, 32'hFFFFFFF0, 32'h00000000,  1, 64'hFFFFFFF0_FFFFFFFF};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 33, 64'h00000000_FFFFFFFF};
        vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'h00000001,  2, 64'hFFFFFFFF_FFFFFFFF};

        resetn = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   64'(busy),  64'd0);
        check("reset_valid",  64'(valid), 64'd0);
        check("reset_result", result,     64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            wait_valid(lat);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_res", i), result, vecs[i].res);
        end

        // Back-to-back issue from the DONE cycle.
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(lat);
        check("b2b_first_res", result, 64'hFFFFFFFE_00000001);
        op    = 2'b01;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy",  64'(busy),  64'd1);
        check("b2b_valid", 64'(valid), 64'd0);
        wait_valid(lat);
        check("b2b_lat", 64'(lat), 64'd2);
        check("b2b_res", result, 64'h00000000_0000000F);

        // Start while busy is ignored.
        issue(2'b11, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd5;
        src_b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(lat);
        check("busy_start_lat", 64'(lat), 64'd29);
        check("busy_start_res", result, 64'h00000002_0000000E);

        // Flush at iteration 10 with a simultaneous start.
        prev = 64'h00000002_0000000E;
        issue(2'b11, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd3;
        src_b = 32'd5;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush_busy",   64'(busy),  64'd0);
        check("flush_valid",  64'(valid), 64'd0);
        check("flush_result", result,     prev);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        issue(2'b01, 32'd3, 32'd5);
        wait_valid(lat);
        check("post_flush_lat", 64'(lat), 64'd2);
        check("post_flush_res", result, 64'h00000000_0000000F);

        // Flush during DONE keeps the current pulse.
        issue(2'b00, 32'hFFFFFFFE, 32'h00000003);
        wait_valid(lat);
        flush = 1'b1;
        #1;
        check("done_flush_valid", 64'(valid), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush_after_valid", 64'(valid), 64'd0);
        check("done_flush_after_res", result, 64'hFFFFFFFF_FFFFFFFA);

        // Asynchronous reset mid-divide.
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002);
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_busy",   64'(busy),  64'd0);
        check("arst_valid",  64'(valid), 64'd0);
        check("arst_result", result,     64'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
        end
        check("arst_no_valid", 64'(seen), 64'd0);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_valid(lat);
        check("post_arst_lat", 64'(lat), 64'd33);
        check("post_arst_res", result, 64'h00000000_80000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, giving the operand width in bits; legal values are 8..64.
REQ-002 SHALL provide parameter MUL_LAT, default 2, giving the cycles from accept to result for multiply; legal values are 1..4.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide port src_a, input, WIDTH bits: dividend / multiplicand.
REQ-006 SHALL provide port src_b, input, WIDTH bits: divisor / multiplier.
REQ-007 SHALL provide port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-008 SHALL provide port start, input, 1 bit: operation request.
REQ-009 SHALL provide port flush, input, 1 bit: abort the in-flight operation (exception/branch flush).
REQ-010 SHALL provide port busy, output, 1 bit: an operation is in flight.
REQ-011 SHALL provide port valid, output, 1 bit: single-cycle result-ready pulse.
REQ-012 SHALL provide port result, output, 2*WIDTH bits: {hi, lo}.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE; busy=1 only in MUL and DIV, and valid=1 only in DONE.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE), latching src_a, src_b and op on that edge; start while busy SHALL be ignored.
REQ-015 After accepting a multiply, SHALL go to MUL and enter DONE exactly MUL_LAT edges after the accept edge.
REQ-016 Multiply result SHALL be the full 2*WIDTH product: signed for MULT, zero-extended for MULTU.
REQ-017 After accepting a divide with divisor != 0, SHALL run WIDTH radix-2 restoring iterations plus 1 sign-fix cycle, entering DONE WIDTH+1 edges after accept.
REQ-018 Divide result SHALL be hi=remainder and lo=quotient.
REQ-019 For DIV, SHALL divide the magnitudes, give the quotient sign = sign(a) XOR sign(b), and give the remainder the sign of the dividend.
REQ-020 For DIV with a = most-negative value and b = -1, SHALL return lo=a and hi=0, with no fault.
REQ-021 For divisor == 0 (DIV or DIVU), SHALL enter DONE 1 edge after accept with lo=all ones and hi=src_a.
REQ-022 result SHALL update only on entry to DONE and SHALL hold that value until the next DONE entry.
REQ-023 From DONE with no accepted start, SHALL return to IDLE; a start accepted in DONE SHALL go directly to MUL or DIV (back-to-back issue).
REQ-024 flush=1 SHALL force IDLE on the next edge from any state: no valid pulse, result unchanged.
REQ-025 flush and start asserted in the same cycle: flush SHALL win and start SHALL be ignored.
REQ-026 flush in DONE SHALL have no effect on the valid pulse already present that cycle.
REQ-027 Operand inputs SHALL NOT be sampled after the accept edge; changing them mid-operation SHALL have no effect.

Reset
REQ-028 resetn=0 SHALL immediately, independent of clk, force state IDLE, busy=0, valid=0, result=0, and clear all iteration registers.
REQ-029 Reset asserted mid-operation SHALL discard the operation; the first accept after resetn rises SHALL behave as from power-up.

Verification (WIDTH=32, MUL_LAT=2)
REQ-030 MULT a=FFFFFFFE, b=00000003 -> valid 2 cycles after accept, result=FFFFFFFF_FFFFFFFA.
REQ-031 MULTU a=b=FFFFFFFF -> result=FFFFFFFE_00000001; back-to-back start issued in the DONE cycle -> accepted with no idle bubble.
REQ-032 DIV a=FFFFFFF9 (-7), b=2 -> valid 33 cycles after accept, lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-033 DIVU a=00000064, b=0 -> valid 1 cycle after accept, lo=FFFFFFFF, hi=00000064.
REQ-034 DIVU started, flush at iteration 10 -> busy=0 next cycle, no valid, result unchanged; new MULTU 3*5 -> result=00000000_0000000F.
REQ-035 resetn pulsed low mid-DIV between clock edges -> busy, valid and result read 0 immediately; no valid after release.
